nf_branch_pred_unit: RTL and testbench

Parametrised successor of the core's branch unit: resolves all six RV32I conditional compares plus unconditional jumps in execute, and adds a dynamic direction predictor (branch history table of 2-bit saturating counters) read in fetch and trained in execute. Sits between the fetch stage (prediction) and the execute stage (resolution, mispredict/flush). It also keeps saturating branch and mispredict statistics for the debug/CSR path.

---
 rtl/nf_branch_pred_unit_pkg.sv | 46 ++++
 rtl/nf_bht.sv | 40 ++++
 rtl/nf_branch_pred_unit.sv | 88 ++++++++
 tb/tb_nf_branch_pred_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nf_branch_pred_unit_pkg.sv
// Shared branch-unit constants: funct3 branch codes, BHT counter encodings,
// branch_type bit positions and the compare-to-condition helpers.
package nf_branch_pred_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;
    localparam logic [1:0] CTR_RST = CTR_WNT;

    localparam int BT_COND = 0;
    localparam int BT_JUMP = 3;

    typedef struct packed {
        logic eq;
        logic lt;
        logic ltu;
    } br_cmp_t;

    function automatic logic br_f3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    function automatic logic br_cond(input logic [2:0] f3, input br_cmp_t c);
        logic r;
        r = 1'b0;
        case (f3)
            F3_BEQ:  r = c.eq;
            F3_BNE:  r = !c.eq;
            F3_BLT:  r = c.lt;
            F3_BGE:  r = !c.lt;
            F3_BLTU: r = c.ltu;
            F3_BGEU: r = !c.ltu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/nf_bht.sv
// Branch history table: DEPTH x 2-bit saturating counters with an async
// fetch read port and a synchronous read-modify-write training port.
module nf_bht
    import nf_branch_pred_unit_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    logic [DEPTH-1:0][1:0] ctr_q, ctr_d;
    logic [1:0]            wr_cur;

    // Read sees the registered array, so a same-cycle write is not forwarded.
    assign rd_taken_o = (ctr_q[rd_idx_i] >= CTR_WT);
    assign wr_cur     = ctr_q[wr_idx_i];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en_i) begin
            if (wr_taken_i && wr_cur != CTR_ST)
                ctr_d[wr_idx_i] = wr_cur + 2'd1;
            else if (!wr_taken_i && wr_cur != CTR_SNT)
                ctr_d[wr_idx_i] = wr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ctr_q <= {DEPTH{CTR_RST}};
        else       ctr_q <= ctr_d;
    end

endmodule

// File: rtl/nf_branch_pred_unit.sv
// Branch resolution with BHT direction prediction: compares, mispredict and
// its registered flush, plus saturating branch/mispredict statistics.
module nf_branch_pred_unit
    import nf_branch_pred_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int STAT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   if_pc_i,
    output logic              if_pred_taken_o,
    input  logic              ex_valid_i,
    input  logic [XLEN-1:0]   ex_pc_i,
    input  logic [3:0]        branch_type_i,
    input  logic [2:0]        branch_funct3_i,
    input  logic [XLEN-1:0]   d1_i,
    input  logic [XLEN-1:0]   d2_i,
    input  logic              ex_pred_taken_i,
    output logic              pc_src_o,
    output logic              mispredict_o,
    output logic              flush_o,
    output logic [STAT_W-1:0] br_cnt_o,
    output logic [STAT_W-1:0] miss_cnt_o
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    br_cmp_t           cmp;
    logic              cond, is_jump, counted;
    logic              flush_q;
    logic [STAT_W-1:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;
    logic              unused_bits;

    assign cmp.eq  = (d1_i == d2_i);
    assign cmp.lt  = ($signed(d1_i) < $signed(d2_i));
    assign cmp.ltu = (d1_i < d2_i);
    assign cond    = br_cond(branch_funct3_i, cmp);

    // A jump bit overrides the conditional bit: taken, never trained or counted.
    assign is_jump = ex_valid_i && branch_type_i[BT_JUMP];
    assign counted = ex_valid_i && branch_type_i[BT_COND] && !branch_type_i[BT_JUMP]
                     && br_f3_legal(branch_funct3_i);

    assign pc_src_o     = (ex_valid_i && branch_type_i[BT_COND] && cond) || is_jump;
    assign mispredict_o = counted && (pc_src_o != ex_pred_taken_i);

    nf_bht #(.DEPTH(BHT_DEPTH), .IDX_W(IDX_W)) u_bht (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (if_pc_i[IDX_W+1:2]),
        .rd_taken_o (if_pred_taken_o),
        .wr_en_i    (counted),
        .wr_idx_i   (ex_pc_i[IDX_W+1:2]),
        .wr_taken_i (pc_src_o)
    );

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (counted && br_cnt_q != '1)
            br_cnt_d = br_cnt_q + STAT_ONE;
        if (mispredict_o && miss_cnt_q != '1)
            miss_cnt_d = miss_cnt_q + STAT_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_q    <= 1'b0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            flush_q    <= mispredict_o;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign flush_o    = flush_q;
    assign br_cnt_o   = br_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

    // PC bits outside the index field and branch_type[2:1] are don't-care here.
    assign unused_bits = ^{if_pc_i, ex_pc_i, branch_type_i};

endmodule

// File: tb/tb_nf_branch_pred_unit.sv
// Randomized bench with a behavioural table/statistics model plus directed
// literal checks of reset, compares, saturation, collisions and aliasing.
module tb_nf_branch_pred_unit;

    localparam int XLEN      = 32;
    localparam int BHT_DEPTH = 64;
    localparam int STAT_W    = 8;
    localparam int STAT_MAX  = (1 << STAT_W) - 1;

    logic              clk;
    logic              rst;
    logic [XLEN-1:0]   if_pc, ex_pc, d1, d2;
    logic              if_pred_taken, ex_valid, ex_pred_taken;
    logic [3:0]        branch_type;
    logic [2:0]        branch_funct3;
    logic              pc_src, mispredict, flush;
    logic [STAT_W-1:0] br_cnt, miss_cnt;

    int checks   = 0;
    int failures = 0;

    nf_branch_pred_unit #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .STAT_W(STAT_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .if_pc_i         (if_pc),
        .if_pred_taken_o (if_pred_taken),
        .ex_valid_i      (ex_valid),
        .ex_pc_i         (ex_pc),
        .branch_type_i   (branch_type),
        .branch_funct3_i (branch_funct3),
        .d1_i            (d1),
        .d2_i            (d2),
        .ex_pred_taken_i (ex_pred_taken),
        .pc_src_o        (pc_src),
        .mispredict_o    (mispredict),
        .flush_o         (flush),
        .br_cnt_o        (br_cnt),
        .miss_cnt_o      (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_ctr [BHT_DEPTH];
    int  m_br, m_miss;
    bit  m_flush;
    bit  m_ok = 0;

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc / 4) % BHT_DEPTH);
    endfunction

    function automatic bit m_taken_cond(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f3)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        bit jump, is_cond, cnt, taken, miss;
        jump    = ex_valid && branch_type[3];
        is_cond = ex_valid && branch_type[0] && !jump;
        cnt     = is_cond && (branch_funct3 != 3'd2) && (branch_funct3 != 3'd3);
        taken   = jump || (is_cond && m_taken_cond(branch_funct3, d1, d2));
        miss    = cnt && (taken != ex_pred_taken);
        if (m_ok) begin
            chk("pc_src", 64'(pc_src), 64'(taken));
            chk("mispredict", 64'(mispredict), 64'(miss));
            chk("flush", 64'(flush), 64'(m_flush));
            chk("if_pred_taken", 64'(if_pred_taken), 64'(m_ctr[idx_of(if_pc)] >= 2));
            chk("br_cnt", 64'(br_cnt), 64'(m_br));
            chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
        end
        if (rst) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_br = 0; m_miss = 0; m_flush = 0; m_ok = 1;
        end else if (m_ok) begin
            m_flush = miss;
            if (cnt) begin
                int k;
                k = idx_of(ex_pc);
                m_ctr[k] = taken ? ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3)
                                 : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
                if (m_br < STAT_MAX) m_br++;
                if (miss && m_miss < STAT_MAX) m_miss++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [XLEN-1:0] pc, input logic [3:0] bt, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic pred);
        ex_valid = 1'b1; ex_pc = pc; branch_type = bt; branch_funct3 = f3;
        d1 = a; d2 = b; ex_pred_taken = pred;
        #1;
    endtask

    task automatic idle(input logic [XLEN-1:0] ipc);
        ex_valid = 1'b0; branch_type = 4'd0; if_pc = ipc;
        #1;
    endtask

    initial begin
        rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; branch_type = '0;
        branch_funct3 = '0; d1 = '0; d2 = '0; ex_pred_taken = 1'b0;
        tick; tick;
        rst = 1'b0;

        // reset state and first mispredict
        idle(32'h40);
        chk("rst_pred", 64'(if_pred_taken), 64'd0);
        chk("rst_br_cnt", 64'(br_cnt), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        drv(32'h40, 4'b0001, 3'd0, 32'd5, 32'd5, 1'b0);
        chk("beq_pc_src", 64'(pc_src), 64'd1);
        chk("beq_mispredict", 64'(mispredict), 64'd1);
        tick; idle(32'h40);
        chk("beq_flush", 64'(flush), 64'd1);
        chk("beq_trained_pred", 64'(if_pred_taken), 64'd1);
        chk("beq_br_cnt", 64'(br_cnt), 64'd1);
        chk("beq_miss_cnt", 64'(miss_cnt), 64'd1);
        tick; idle(32'h40);
        chk("flush_single_pulse", 64'(flush), 64'd0);

        // signed vs unsigned
        drv(32'h300, 4'b0001, 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("blt_neg", 64'(pc_src), 64'd1);
        tick; drv(32'h300, 4'b0001, 3'd6, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("bltu_big", 64'(pc_src), 64'd0);
        tick; drv(32'h300, 4'b0001, 3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("bge_neg", 64'(pc_src), 64'd0);
        tick; drv(32'h300, 4'b0001, 3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("bgeu_big", 64'(pc_src), 64'd1);
        tick;

        // saturation at index 48 (fresh 01)
        for (int i = 0; i < 4; i++) begin
            drv(32'hC0, 4'b0001, 3'd0, 32'd7, 32'd7, 1'b1); tick;
        end
        idle(32'hC0);
        chk("sat_hi_pred", 64'(if_pred_taken), 64'd1);
        drv(32'hC0, 4'b0001, 3'd0, 32'd7, 32'd8, 1'b1); tick; idle(32'hC0);
        chk("sat_hi_minus1", 64'(if_pred_taken), 64'd1);
        for (int i = 0; i < 5; i++) begin
            drv(32'hC0, 4'b0001, 3'd1, 32'd7, 32'd7, 1'b0); tick;
        end
        drv(32'hC0, 4'b0001, 3'd0, 32'd1, 32'd1, 1'b0); tick; idle(32'hC0);
        chk("sat_lo_plus1", 64'(if_pred_taken), 64'd0);
        drv(32'hC0, 4'b0001, 3'd0, 32'd1, 32'd1, 1'b0); tick; idle(32'hC0);
        chk("sat_lo_plus2", 64'(if_pred_taken), 64'd1);

        // jal, jump+cond, illegal funct3
        drv(32'h44, 4'b1000, 3'd0, 32'd1, 32'd2, 1'b0);
        chk("jal_pc_src", 64'(pc_src), 64'd1);
        chk("jal_mispredict", 64'(mispredict), 64'd0);
        tick; drv(32'h44, 4'b1001, 3'd0, 32'd1, 32'd2, 1'b0);
        chk("jmp_cond_pc_src", 64'(pc_src), 64'd1);
        chk("jmp_cond_mispredict", 64'(mispredict), 64'd0);
        tick; drv(32'h44, 4'b0001, 3'd2, 32'd3, 32'd3, 1'b1);
        chk("f3_010_pc_src", 64'(pc_src), 64'd0);
        chk("f3_010_mispredict", 64'(mispredict), 64'd0);
        tick; idle(32'h44);
        chk("jump_no_train", 64'(if_pred_taken), 64'd0);
        chk("jump_no_flush", 64'(flush), 64'd0);

        // same-index collision: read-before-write
        if_pc = 32'h80;
        drv(32'h80, 4'b0001, 3'd0, 32'd9, 32'd9, 1'b1);
        chk("collide_old", 64'(if_pred_taken), 64'd0);
        tick; idle(32'h80);
        chk("collide_new", 64'(if_pred_taken), 64'd1);

        // alias: 0x010 and 0x110 share index 4
        idle(32'h110);
        chk("alias_before", 64'(if_pred_taken), 64'd0);
        drv(32'h010, 4'b0001, 3'd0, 32'd2, 32'd2, 1'b1); tick; idle(32'h110);
        chk("alias_after", 64'(if_pred_taken), 64'd1);

        // reset during a mispredicting branch
        rst = 1'b1;
        drv(32'h20, 4'b0001, 3'd0, 32'd4, 32'd4, 1'b0);
        tick; rst = 1'b0; idle(32'h20);
        chk("rstmid_pred", 64'(if_pred_taken), 64'd0);
        chk("rstmid_flush", 64'(flush), 64'd0);
        chk("rstmid_br_cnt", 64'(br_cnt), 64'd0);
        chk("rstmid_miss_cnt", 64'(miss_cnt), 64'd0);
        tick;

        // random phase, narrow index range for collisions and stat saturation
        for (int n = 0; n < 3000; n++) begin
            logic [XLEN-1:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            rst           = ($urandom_range(0, 499) == 0);
            if_pc         = {$urandom_range(0, 255), 2'b00} ^ {$urandom_range(0, 3), 8'h00, 2'b00};
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_pc         = {$urandom_range(0, 15), 2'b00} + ($urandom_range(0, 1) ? 32'h100 : 32'h0);
            branch_type   = 4'($urandom_range(0, 15));
            branch_funct3 = 3'($urandom_range(0, 7));
            d1 = a; d2 = b;
            ex_pred_taken = 1'($urandom_range(0, 1));
            tick;
        end
        rst = 1'b0; ex_valid = 1'b0;
        tick; tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
